// File: rtl/dff_pipe_ap.sv
// dff_pipe_ap: elastic preset register pipeline with valid/ready, bubble collapsing, flush and occupancy
module dff_pipe_ap #(
  parameter int WIDTH = 32,
  parameter int STAGES = 4,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(STAGES+1)-1:0]  occupancy
);
  localparam int OW = $clog2(STAGES+1);
  logic [WIDTH-1:0] data_q [STAGES];
  logic [WIDTH-1:0] data_d [STAGES];
  logic [WIDTH-1:0] d_in [STAGES];
  logic [STAGES-1:0] v_q, v_d, v_in, rdy;
  logic [OW-1:0] occ_q, occ_d;
  logic acc, in_xfer, out_xfer;
  // rdy[i] is set when any stage at or after i is empty, or the output drains
  always_comb begin
    acc = out_ready;
    rdy = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc = acc | ~v_q[i];
      rdy[i] = acc;
    end
  end
  always_comb begin
    d_in = data_q;
    v_in = v_q;
    d_in[0] = in_data;
    v_in[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      d_in[i] = data_q[i-1];
      v_in[i] = v_q[i-1];
    end
    v_d = v_q;
    data_d = data_q;
    for (int i = 0; i < STAGES; i++) begin
      v_d[i] = flush ? 1'b0 : (rdy[i] ? v_in[i] : v_q[i]);
      data_d[i] = (~flush & rdy[i] & v_in[i]) ? d_in[i] : data_q[i];
    end
  end
  assign in_ready = rdy[0] & ~flush & rst_n;
  assign out_valid = v_q[STAGES-1];
  assign out_data = data_q[STAGES-1];
  assign in_xfer = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;
  assign occ_d = flush ? '0 : occ_q + OW'(in_xfer) - OW'(out_xfer);
  assign occupancy = occ_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      occ_q <= '0;
      data_q <= '{default: PRESET_VAL};
    end else begin
      v_q <= v_d;
      occ_q <= occ_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_dff_pipe_ap.sv
// tb_dff_pipe_ap: directed bench with an item-position queue model for the 4-stage pipe plus a 1-stage instance
module tb_dff_pipe_ap;
  localparam int S = 4;
  logic clk = 0, rst_n = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [31:0] in_data = 0, out_data;
  logic [2:0] occupancy;
  logic flush1 = 0, in_valid1 = 0, out_ready1 = 0, in_ready1, out_valid1;
  logic [7:0] in_data1 = 0, out_data1;
  logic [0:0] occupancy1;
  int total = 0, bad = 0, acc, mb;
  bit ev;
  typedef struct {logic [31:0] d; int p;} ent_t;
  ent_t q[$];
  logic [31:0] got[$];

  always #5 clk = ~clk;

  dff_pipe_ap dut (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .occupancy(occupancy));
  dff_pipe_ap #(.WIDTH(8), .STAGES(1), .PRESET_VAL(8'h5A)) dut1 (.clk(clk), .rst_n(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .out_valid(out_valid1),
    .out_ready(out_ready1), .out_data(out_data1), .occupancy(occupancy1));

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, a, e);
    end
  endtask

  // Items in flight with their stage position; an item steps forward if the slot ahead is free after the item ahead moves
  function automatic bit m_in_ready();
    int b = out_ready ? S + 1 : S;
    for (int k = 0; k < q.size(); k++) b = (q[k].p + 1 < b) ? q[k].p + 1 : q[k].p;
    return !flush && b > 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) q.delete();
    else begin
      mb = out_ready ? S + 1 : S;
      for (int k = 0; k < q.size(); k++) begin
        mb = (q[k].p + 1 < mb) ? q[k].p + 1 : q[k].p;
        q[k].p = mb;
      end
      if (q.size() > 0 && q[0].p == S) void'(q.pop_front());
      if (in_valid && mb > 0) q.push_back('{in_data, 0});
    end
  end

  always @(negedge clk) if (rst_n) begin
    ev = q.size() > 0 && q[0].p == S - 1;
    chk("in_ready", 64'(in_ready), 64'(m_in_ready()));
    chk("out_valid", 64'(out_valid), 64'(ev));
    if (ev) chk("out_data", 64'(out_data), 64'(q[0].d));
    chk("occupancy", 64'(occupancy), 64'(q.size()));
    if (out_valid && out_ready) got.push_back(out_data);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    in_valid = 0;
    repeat (n) cyc();
  endtask

  task automatic offer(input int first, input int n, input int maxc, output int a);
    a = 0;
    for (int c = 0; c < maxc && a < n; c++) begin
      in_valid = 1;
      in_data = 32'(first + a);
      #1;
      if (in_ready) a++;
      cyc();
    end
    in_valid = 0;
  endtask

  task automatic chk_got(input string nm, input int first, input int n);
    chk({nm, "_count"}, 64'(got.size()), 64'(n));
    if (got.size() == n) for (int k = 0; k < n; k++) chk(nm, 64'(got[k]), 64'(first + k));
  endtask

  initial begin
    #1 rst_n = 0;
    #2;
    chk("rst_out_data", 64'(out_data), 64'(32'hFFFF_FFFF));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_occupancy", 64'(occupancy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst1_out_data", 64'(out_data1), 64'(8'h5A));
    chk("rst1_out_valid", 64'(out_valid1), 64'(0));
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    cyc();
    // streaming with 4-edge latency
    out_ready = 1;
    in_valid = 1;
    for (int k = 1; k <= 8; k++) begin
      in_data = 32'(k);
      cyc();
      if (k == 4) begin
        chk("stream_first_valid", 64'(out_valid), 64'(1));
        chk("stream_first_data", 64'(out_data), 64'(1));
        chk("stream_occ", 64'(occupancy), 64'(4));
      end
    end
    drain(6);
    chk_got("stream_order", 1, 8);
    // stall and fill
    got.delete();
    out_ready = 0;
    offer(11, 6, 6, acc);
    chk("stall_accepted", 64'(acc), 64'(4));
    chk("stall_occ", 64'(occupancy), 64'(4));
    chk("stall_in_ready", 64'(in_ready), 64'(0));
    out_ready = 1;
    offer(15, 2, 10, acc);
    chk("stall_rest_accepted", 64'(acc), 64'(2));
    drain(6);
    chk_got("stall_order", 11, 6);
    // bubble collapse
    got.delete();
    out_ready = 0;
    in_valid = 1; in_data = 32'hA; cyc();
    in_valid = 0; cyc(); cyc();
    in_valid = 1; in_data = 32'hB; cyc();
    drain(3);
    chk("bubble_out_data", 64'(out_data), 64'(32'hA));
    chk("bubble_occ", 64'(occupancy), 64'(2));
    out_ready = 1;
    cyc();
    chk("bubble_no_gap_valid", 64'(out_valid), 64'(1));
    chk("bubble_no_gap_data", 64'(out_data), 64'(32'hB));
    cyc();
    chk("bubble_empty", 64'(out_valid), 64'(0));
    chk_got("bubble_order", 10, 2);
    // flush with simultaneous input
    got.delete();
    out_ready = 0;
    in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'(21 + k);
      cyc();
    end
    chk("flush_pre_occ", 64'(occupancy), 64'(3));
    flush = 1; in_data = 32'h99;
    #1 chk("flush_in_ready", 64'(in_ready), 64'(0));
    cyc();
    flush = 0; in_valid = 0;
    chk("flush_occ", 64'(occupancy), 64'(0));
    chk("flush_out_valid", 64'(out_valid), 64'(0));
    out_ready = 1;
    drain(6);
    chk("flush_nothing_out", 64'(got.size()), 64'(0));
    // reset mid-transfer
    out_ready = 1; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      in_data = 32'(31 + k);
      cyc();
    end
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_data", 64'(out_data), 64'(32'hFFFF_FFFF));
    chk("midrst_occ", 64'(occupancy), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    in_valid = 0;
    #3 rst_n = 1;
    cyc();
    drain(6);
    chk("midrst_nothing_out", 64'(got.size()), 64'(0));
    // single-stage pass-through
    out_ready1 = 1; in_valid1 = 1;
    for (int k = 0; k < 5; k++) begin
      in_data1 = 8'(16 + k);
      #1 chk("s1_in_ready", 64'(in_ready1), 64'(1));
      cyc();
      chk("s1_out_valid", 64'(out_valid1), 64'(1));
      chk("s1_out_data", 64'(out_data1), 64'(16 + k));
      chk("s1_occ", 64'(occupancy1), 64'(1));
    end
    out_ready1 = 0; in_data1 = 8'h20;
    #1 chk("s1_full_in_ready", 64'(in_ready1), 64'(0));
    cyc();
    chk("s1_hold_data", 64'(out_data1), 64'(8'h14));
    out_ready1 = 1; in_valid1 = 0;
    cyc();
    chk("s1_empty_valid", 64'(out_valid1), 64'(0));
    chk("s1_empty_occ", 64'(occupancy1), 64'(0));
    chk("s1_stale_data", 64'(out_data1), 64'(8'h14));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
